de2_sram_arbiter: RTL and testbench
===================================

# de2_sram_arbiter

Shares the single DE2 asynchronous 256K×16 SRAM between two clk-domain requesters: port A (video framebuffer fetch, read-only, high priority) and port B (general read/write, e.g. CPU/loader). It sequences every SRAM access cycle and drives the `de2_sram_out__*` bundle, including the tristate enable, consumed by the board top-level pads. It sits between the DUT's memory clients and the SRAM pin wrapper.

## Interface
- `STARVE_LIMIT`, 8: consecutive A grants allowed while B waits (only with the macro); range 1–255.
- `clk` in 1: system clock, 50 MHz (`clk_50`).
- `reset` in 1: asynchronous, active-high reset.
- `a_req` in 1: A read request; hold with `a_addr` until `a_ack`.
- `a_addr` in 18: A word address.
- `a_ack` out 1: one-cycle pulse, first cycle of the granted A access.
- `a_rdata_valid` out 1: one-cycle pulse with `a_rdata`.
- `a_rdata` out 16: A read data.
- `b_req` in 1, `b_we` in 1, `b_addr` in 18, `b_be` in 2 (active-high byte enables), `b_wdata` in 16: B request; hold until `b_ack`.
- `b_ack` out 1, `b_rdata_valid` out 1, `b_rdata` out 16: as for A.
- `de2_sram_out__ce_n`, `__oe_n`, `__we_n` out 1 each; `__be_n` out 2; `__addr` out 18; `__dq` out 16; `__dqe` out 1: registered SRAM drive.
- `de2_sram_in__dq` in 16: SRAM data pins.

## Operation
- FSM states: IDLE, RD_A, RD_B, WR_SETUP, WR_PULSE, WR_HOLD.
- Decision points: every edge in IDLE; the edge ending RD_B; the edge ending WR_HOLD. At a decision point: A if `a_req` (unless starve override), else B if `b_req`, else IDLE.
- A granted → RD_A. B with `b_we=0` → RD_A; `b_we=1` → WR_SETUP.
- Transitions: RD_A→RD_B; WR_SETUP→WR_PULSE→WR_HOLD; RD_B/WR_HOLD → next decision.
- A port-B read drives `be_n=00`; write drives `be_n=~b_be`. Addr/wdata/be latched at the grant edge.
- Owner tag registered at grant routes read data and valid to the correct port.
- Idle outputs: `ce_n=1 oe_n=1 we_n=1 be_n=11 dqe=0`; `addr`/`dq` hold last value.
- Reset values: all strobes idle as above; `addr=0 dq=0`; acks, valids 0; rdata 0; FSM IDLE; starve count 0.
- Reset mid-access: immediate return to idle drive, `dqe=0`; in-flight op discarded, no valid pulse.

## Timing
- Grant at edge E0 → C1 is first access cycle, `x_ack=1` in C1 only.
- Read: C1 (RD_A) and C2 (RD_B): `ce_n=0 oe_n=0 we_n=1 dqe=0`. `de2_sram_in__dq` sampled at end of C2; `x_rdata_valid=1` in C3. ack→valid latency 2 cycles; throughput 1 read per 2 cycles.
- Write: C1 WR_SETUP `ce_n=0 oe_n=1 we_n=1 dqe=1`; C2 WR_PULSE `we_n=0`; C3 WR_HOLD `we_n=1 dqe=1`. 1 write per 3 cycles.
- Back-to-back: next access's C1 immediately follows RD_B/WR_HOLD; no idle cycle. `oe_n` never low while `dqe=1`.
- Requesters update `req`/addr on the edge ending their ack cycle; the ack cycle is never a decision point.

## Configuration
- `DE2_SRAM_ARB_STARVE_LIMIT_EN` defined: counter increments on each A grant while `b_req=1`; at a decision point with count==`STARVE_LIMIT` and `b_req=1`, B wins and count clears; clears when `b_req=0` or B granted.
- Undefined: strict A priority, no counter logic; `STARVE_LIMIT` ignored.

## Structure
- Shared package `de2_sram_types`: FSM state enum, owner enum (A/B), `t_de2_sram_out` bundle, idle-drive constant.
- Sub-module `de2_sram_arb_select`: decision logic plus optional starve counter; outputs grant A/B/none.

## Test plan
- A read addr 0x00010, SRAM model holds 0x1234 → `a_ack` C1, `ce_n=oe_n=0` C1–C2, `a_rdata=0x1234` valid in C3.
- B write addr 0x3FFFF data 0xBEEF `b_be=01` → `be_n=10`, `we_n` low exactly C2, `dqe=1` C1–C3; readback 0x??EF low byte only.
- A and B both requesting continuously, macro undefined → B never acked over 1000 cycles; A reads every 2 cycles.
- Same with macro, `STARVE_LIMIT=4` → B acked after every 4 A grants.
- Assert `reset` during WR_PULSE → `we_n=1 dqe=0 ce_n=1` same cycle, no ack/valid after release, FSM IDLE.
- A read then B read back-to-back → `a_rdata_valid` and `b_rdata_valid` two cycles apart, correct data routed per owner.

Source files
------------

// File: rtl/de2_sram_arbiter_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// de2_sram_types: shared FSM/owner/grant enums and SRAM drive bundle.
// Rev 1.0
// ------------------------------------------------------------------
package de2_sram_types;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_A     = 3'd1,
      RD_B     = 3'd2,
      WR_SETUP = 3'd3,
      WR_PULSE = 3'd4,
      WR_HOLD  = 3'd5
   } t_state;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } t_owner;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_A    = 2'd1,
      GNT_B    = 2'd2
   } t_grant;

   typedef struct packed {
      logic        ce_n;
      logic        oe_n;
      logic        we_n;
      logic [1:0]  be_n;
      logic [17:0] addr;
      logic [15:0] dq;
      logic        dqe;
   } t_de2_sram_out;

   localparam t_de2_sram_out SRAM_OUT_IDLE = '{
      ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, be_n: 2'b11,
      addr: 18'd0, dq: 16'd0, dqe: 1'b0
   };

   // Idle strobes but addr/dq keep their last driven value.
   function automatic t_de2_sram_out f_idle_drive(input t_de2_sram_out prev);
      t_de2_sram_out r;
      r      = SRAM_OUT_IDLE;
      r.addr = prev.addr;
      r.dq   = prev.dq;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/de2_sram_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// de2_sram_arbiter_if: requester-side handshake bundle for ports A and B.
// Rev 1.0
// ------------------------------------------------------------------
interface de2_sram_arbiter_if;
   logic        a_req;
   logic [17:0] a_addr;
   logic        a_ack;
   logic        a_rdata_valid;
   logic [15:0] a_rdata;
   logic        b_req;
   logic        b_we;
   logic [17:0] b_addr;
   logic [1:0]  b_be;
   logic [15:0] b_wdata;
   logic        b_ack;
   logic        b_rdata_valid;
   logic [15:0] b_rdata;

   modport master (
      output a_req, a_addr, b_req, b_we, b_addr, b_be, b_wdata,
      input  a_ack, a_rdata_valid, a_rdata, b_ack, b_rdata_valid, b_rdata
   );

   modport slave (
      input  a_req, a_addr, b_req, b_we, b_addr, b_be, b_wdata,
      output a_ack, a_rdata_valid, a_rdata, b_ack, b_rdata_valid, b_rdata
   );
endinterface
`default_nettype wire

// File: rtl/de2_sram_arbiter_select.sv
`default_nettype none
// ------------------------------------------------------------------
// de2_sram_arb_select: A-priority grant decision, optional starve limit.
// Option: DE2_SRAM_ARB_STARVE_LIMIT_EN. Rev 1.0
// ------------------------------------------------------------------
module de2_sram_arb_select
   import de2_sram_types::*;
#(
   parameter int STARVE_LIMIT = 8
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic decide_i,
   input  wire logic a_req_i,
   input  wire logic b_req_i,
   output t_grant    grant_o
);

`ifdef DE2_SRAM_ARB_STARVE_LIMIT_EN
   logic [7:0] starve_cnt_q;
   logic       starve;

   assign starve = b_req_i && (starve_cnt_q == 8'(STARVE_LIMIT));

   always_comb begin
      grant_o = GNT_NONE;
      if (decide_i) begin
         if (a_req_i && !starve) grant_o = GNT_A;
         else if (b_req_i)       grant_o = GNT_B;
      end
   end

   // Counts A grants that B had to sit through.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         starve_cnt_q <= 8'd0;
      else if (!b_req_i || grant_o == GNT_B)
         starve_cnt_q <= 8'd0;
      else if (grant_o == GNT_A)
         starve_cnt_q <= starve_cnt_q + 8'd1;
   end
`else
   logic unused_sel;
   assign unused_sel = clk ^ reset ^ (STARVE_LIMIT != 0);

   always_comb begin
      grant_o = GNT_NONE;
      if (decide_i) begin
         if (a_req_i)      grant_o = GNT_A;
         else if (b_req_i) grant_o = GNT_B;
      end
   end
`endif

endmodule
`default_nettype wire

// File: rtl/de2_sram_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// de2_sram_arbiter: sequences DE2 async SRAM cycles for ports A and B.
// Option: DE2_SRAM_ARB_STARVE_LIMIT_EN. Rev 1.0
// ------------------------------------------------------------------
module de2_sram_arbiter
   import de2_sram_types::*;
#(
   parameter int STARVE_LIMIT = 8
) (
   input  wire logic        clk,
   input  wire logic        reset,
   de2_sram_arbiter_if.slave bus,
   output logic             de2_sram_out__ce_n,
   output logic             de2_sram_out__oe_n,
   output logic             de2_sram_out__we_n,
   output logic [1:0]       de2_sram_out__be_n,
   output logic [17:0]      de2_sram_out__addr,
   output logic [15:0]      de2_sram_out__dq,
   output logic             de2_sram_out__dqe,
   input  wire logic [15:0] de2_sram_in__dq
);

   t_state        state_q;
   t_owner        owner_q;
   t_de2_sram_out out_q;
   logic          a_ack_q, b_ack_q, a_vld_q, b_vld_q;
   logic [15:0]   a_rdata_q, b_rdata_q;
   logic          decide;
   t_grant        grant;

   assign decide = (state_q == IDLE) || (state_q == RD_B) || (state_q == WR_HOLD);

   de2_sram_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
      .clk      (clk),
      .reset    (reset),
      .decide_i (decide),
      .a_req_i  (bus.a_req),
      .b_req_i  (bus.b_req),
      .grant_o  (grant)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= OWN_A;
         out_q     <= SRAM_OUT_IDLE;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_vld_q   <= 1'b0;
         b_vld_q   <= 1'b0;
         a_rdata_q <= 16'd0;
         b_rdata_q <= 16'd0;
      end else begin
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
         a_vld_q <= 1'b0;
         b_vld_q <= 1'b0;
         // The edge ending RD_B both samples the pins and makes the next grant.
         if (state_q == RD_B) begin
            if (owner_q == OWN_A) begin
               a_rdata_q <= de2_sram_in__dq;
               a_vld_q   <= 1'b1;
            end else begin
               b_rdata_q <= de2_sram_in__dq;
               b_vld_q   <= 1'b1;
            end
         end
         case (state_q)
            RD_A: state_q <= RD_B;
            WR_SETUP: begin
               state_q    <= WR_PULSE;
               out_q.we_n <= 1'b0;
            end
            WR_PULSE: begin
               state_q    <= WR_HOLD;
               out_q.we_n <= 1'b1;
            end
            default: begin
               case (grant)
                  GNT_A: begin
                     state_q <= RD_A;
                     owner_q <= OWN_A;
                     a_ack_q <= 1'b1;
                     out_q   <= '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, be_n: 2'b00,
                                  addr: bus.a_addr, dq: out_q.dq, dqe: 1'b0};
                  end
                  GNT_B: begin
                     owner_q <= OWN_B;
                     b_ack_q <= 1'b1;
                     if (bus.b_we) begin
                        state_q <= WR_SETUP;
                        out_q   <= '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, be_n: ~bus.b_be,
                                     addr: bus.b_addr, dq: bus.b_wdata, dqe: 1'b1};
                     end else begin
                        state_q <= RD_A;
                        out_q   <= '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, be_n: 2'b00,
                                     addr: bus.b_addr, dq: out_q.dq, dqe: 1'b0};
                     end
                  end
                  default: begin
                     state_q <= IDLE;
                     out_q   <= f_idle_drive(out_q);
                  end
               endcase
            end
         endcase
      end
   end

   assign bus.a_ack            = a_ack_q;
   assign bus.a_rdata_valid    = a_vld_q;
   assign bus.a_rdata          = a_rdata_q;
   assign bus.b_ack            = b_ack_q;
   assign bus.b_rdata_valid    = b_vld_q;
   assign bus.b_rdata          = b_rdata_q;

   assign de2_sram_out__ce_n = out_q.ce_n;
   assign de2_sram_out__oe_n = out_q.oe_n;
   assign de2_sram_out__we_n = out_q.we_n;
   assign de2_sram_out__be_n = out_q.be_n;
   assign de2_sram_out__addr = out_q.addr;
   assign de2_sram_out__dq   = out_q.dq;
   assign de2_sram_out__dqe  = out_q.dqe;

endmodule
`default_nettype wire

// File: tb/tb_de2_sram_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_de2_sram_arbiter: directed + randomized bench with SRAM and memory model.
// Option: DE2_SRAM_ARB_STARVE_LIMIT_EN. Rev 1.0
// ------------------------------------------------------------------
module tb_de2_sram_arbiter;

   localparam int LIMIT = 4;
`ifdef DE2_SRAM_ARB_STARVE_LIMIT_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   typedef struct {
      int          due;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   de2_sram_arbiter_if bus();

   logic        ce_n, oe_n, we_n, dqe;
   logic [1:0]  be_n;
   logic [17:0] addr;
   logic [15:0] dq, dq_in;

   de2_sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk                (clk),
      .reset              (reset),
      .bus                (bus),
      .de2_sram_out__ce_n (ce_n),
      .de2_sram_out__oe_n (oe_n),
      .de2_sram_out__we_n (we_n),
      .de2_sram_out__be_n (be_n),
      .de2_sram_out__addr (addr),
      .de2_sram_out__dq   (dq),
      .de2_sram_out__dqe  (dqe),
      .de2_sram_in__dq    (dq_in)
   );

   // Asynchronous SRAM: data out while selected and output-enabled.
   logic [15:0] mem [0:262143];
   assign dq_in = (!ce_n && !oe_n) ? mem[addr] : 16'hDEAD;
   always @(negedge clk) begin
      if (!ce_n && !we_n && dqe) begin
         if (!be_n[0]) mem[addr][7:0]  <= dq[7:0];
         if (!be_n[1]) mem[addr][15:8] <= dq[15:8];
      end
   end

   int bus_viol = 0;
   always @(negedge clk) if (!oe_n && dqe) bus_viol++;

   // Reference memory: what the SRAM should hold after the grants so far.
   logic [15:0] ref_mem [int];
   function automatic logic [15:0] init_pat(input int a);
      logic [31:0] v;
      v = a;
      return v[15:0] ^ 16'h5A5A;
   endfunction
   function automatic logic [15:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
   endfunction
   function automatic void ref_wr(input int a, input logic [15:0] d, input logic [1:0] be);
      logic [15:0] v;
      v = ref_rd(a);
      if (be[0]) v[7:0]  = d[7:0];
      if (be[1]) v[15:8] = d[15:8];
      ref_mem[a] = v;
   endfunction

   int n_checks = 0;
   int n_fail   = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.a_req = 1'b0; bus.a_addr = '0;
      bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_be = 2'b00; bus.b_wdata = '0;
   endtask

   task automatic preset(input logic [17:0] a, input logic [15:0] d);
      mem[a] = d;
      ref_wr(int'(a), d, 2'b11);
   endtask

   task automatic test_reset;
      idle_inputs();
      reset = 1'b1;
      repeat (3) tick();
      n_checks++; if ({ce_n, oe_n, we_n, be_n, dqe} !== 6'b111110) begin n_fail++;
         $display("FAIL reset_strobes: got %b expected 111110", {ce_n, oe_n, we_n, be_n, dqe}); end
      n_checks++; if ({addr, dq} !== 34'd0) begin n_fail++;
         $display("FAIL reset_addr_dq: got %h/%h expected 0/0", addr, dq); end
      n_checks++; if ({bus.a_ack, bus.b_ack, bus.a_rdata_valid, bus.b_rdata_valid, bus.a_rdata, bus.b_rdata} !== 36'd0) begin n_fail++;
         $display("FAIL reset_handshake: got %b %h %h expected all zero",
                  {bus.a_ack, bus.b_ack, bus.a_rdata_valid, bus.b_rdata_valid}, bus.a_rdata, bus.b_rdata); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_a_read;
      preset(18'h00010, 16'h1234);
      bus.a_req = 1'b1; bus.a_addr = 18'h00010;
      tick();
      n_checks++; if ({bus.a_ack, ce_n, oe_n, we_n, dqe, addr} !== {5'b10010, 18'h00010}) begin n_fail++;
         $display("FAIL a_read_c1: got ack/ce/oe/we/dqe %b addr %h expected 10010 addr 00010",
                  {bus.a_ack, ce_n, oe_n, we_n, dqe}, addr); end
      bus.a_req = 1'b0;
      tick();
      n_checks++; if ({bus.a_ack, ce_n, oe_n, dqe} !== 4'b0000) begin n_fail++;
         $display("FAIL a_read_c2: got ack/ce/oe/dqe %b expected 0000", {bus.a_ack, ce_n, oe_n, dqe}); end
      tick();
      n_checks++; if ({bus.a_rdata_valid, bus.a_rdata, ce_n} !== {1'b1, 16'h1234, 1'b1}) begin n_fail++;
         $display("FAIL a_read_c3: got valid %b data %h ce_n %b expected 1 1234 1",
                  bus.a_rdata_valid, bus.a_rdata, ce_n); end
      tick();
      n_checks++; if (bus.a_rdata_valid !== 1'b0) begin n_fail++;
         $display("FAIL a_read_valid_pulse: got %b expected 0", bus.a_rdata_valid); end
   endtask

   task automatic test_b_write;
      preset(18'h3FFFF, 16'hA5C3);
      bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 18'h3FFFF; bus.b_wdata = 16'hBEEF; bus.b_be = 2'b01;
      tick();
      n_checks++; if ({bus.b_ack, ce_n, oe_n, we_n, dqe, be_n, dq} !== {7'b1011110, 16'hBEEF}) begin n_fail++;
         $display("FAIL b_write_c1: got ack/ce/oe/we/dqe/be_n %b dq %h expected 1011110 BEEF",
                  {bus.b_ack, ce_n, oe_n, we_n, dqe, be_n}, dq); end
      ref_wr(18'h3FFFF, 16'hBEEF, 2'b01);
      bus.b_req = 1'b0; bus.b_we = 1'b0;
      tick();
      n_checks++; if ({we_n, dqe, oe_n, ce_n} !== 4'b0110) begin n_fail++;
         $display("FAIL b_write_c2: got we/dqe/oe/ce %b expected 0110", {we_n, dqe, oe_n, ce_n}); end
      tick();
      n_checks++; if ({we_n, dqe, ce_n} !== 3'b110) begin n_fail++;
         $display("FAIL b_write_c3: got we/dqe/ce %b expected 110", {we_n, dqe, ce_n}); end
      tick();
      n_checks++; if ({dqe, ce_n, be_n} !== 4'b0111) begin n_fail++;
         $display("FAIL b_write_idle: got dqe/ce/be_n %b expected 0111", {dqe, ce_n, be_n}); end
      bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 18'h3FFFF;
      tick();
      n_checks++; if ({bus.b_ack, be_n} !== 3'b100) begin n_fail++;
         $display("FAIL b_read_c1: got ack/be_n %b expected 100", {bus.b_ack, be_n}); end
      bus.b_req = 1'b0;
      repeat (2) tick();
      n_checks++; if ({bus.b_rdata_valid, bus.b_rdata} !== {1'b1, ref_rd(18'h3FFFF)}) begin n_fail++;
         $display("FAIL b_readback: got valid %b data %h expected 1 %h",
                  bus.b_rdata_valid, bus.b_rdata, ref_rd(18'h3FFFF)); end
      tick();
   endtask

   task automatic test_starve;
      int k = 0, nb = 0, bad = 0, gap_bad = 0, last = -1;
      bus.a_req = 1'b1; bus.a_addr = 18'h00100;
      bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 18'h00005;
      for (int c = 0; c < 1000; c++) begin
         tick();
         if (bus.a_ack || bus.b_ack) begin
            if (bus.a_ack === bus.b_ack) bad++;
            else if (bus.b_ack !== (STARVE_EN && (k % (LIMIT + 1) == LIMIT))) bad++;
            if (last >= 0 && c - last != 2) gap_bad++;
            if (bus.b_ack) nb++;
            if (bus.a_ack) bus.a_addr = bus.a_addr + 18'd1;
            last = c;
            k++;
         end
      end
      idle_inputs();
      repeat (4) tick();
      n_checks++; if (bad != 0) begin n_fail++;
         $display("FAIL starve_order: got %0d wrong grants expected 0", bad); end
      n_checks++; if (gap_bad != 0 || k != 500) begin n_fail++;
         $display("FAIL starve_throughput: got %0d grants, %0d bad gaps expected 500, 0", k, gap_bad); end
      n_checks++; if (nb != (STARVE_EN ? 500 / (LIMIT + 1) : 0)) begin n_fail++;
         $display("FAIL starve_b_count: got %0d expected %0d", nb, STARVE_EN ? 500 / (LIMIT + 1) : 0); end
   endtask

   task automatic test_reset_mid_write;
      int seen = 0;
      preset(18'h0002A, 16'h1111);
      bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 18'h0002A; bus.b_wdata = 16'h9999; bus.b_be = 2'b11;
      tick();
      bus.b_req = 1'b0; bus.b_we = 1'b0;
      tick();
      n_checks++; if (we_n !== 1'b0) begin n_fail++;
         $display("FAIL rst_mid_pulse: got we_n %b expected 0", we_n); end
      #1 reset = 1'b1;
      #1;
      n_checks++; if ({we_n, dqe, ce_n} !== 3'b101) begin n_fail++;
         $display("FAIL rst_mid_drive: got we/dqe/ce %b expected 101", {we_n, dqe, ce_n}); end
      tick();
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (bus.a_ack || bus.b_ack || bus.a_rdata_valid || bus.b_rdata_valid) seen++;
      end
      n_checks++; if (seen != 0) begin n_fail++;
         $display("FAIL rst_no_handshake: got %0d events expected 0", seen); end
      bus.a_req = 1'b1; bus.a_addr = 18'h0002A;
      tick();
      n_checks++; if (bus.a_ack !== 1'b1) begin n_fail++;
         $display("FAIL rst_fsm_idle: got a_ack %b expected 1", bus.a_ack); end
      bus.a_req = 1'b0;
      repeat (2) tick();
      n_checks++; if ({bus.a_rdata_valid, bus.a_rdata} !== {1'b1, ref_rd(18'h0002A)}) begin n_fail++;
         $display("FAIL rst_write_discarded: got valid %b data %h expected 1 %h",
                  bus.a_rdata_valid, bus.a_rdata, ref_rd(18'h0002A)); end
      tick();
   endtask

   task automatic test_back_to_back;
      preset(18'h00100, 16'hA0A0);
      preset(18'h00200, 16'hB1B1);
      bus.a_req = 1'b1; bus.a_addr = 18'h00100;
      bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 18'h00200;
      tick();
      n_checks++; if ({bus.a_ack, bus.b_ack} !== 2'b10) begin n_fail++;
         $display("FAIL b2b_first: got a/b ack %b expected 10", {bus.a_ack, bus.b_ack}); end
      bus.a_req = 1'b0;
      repeat (2) tick();
      n_checks++; if ({bus.b_ack, bus.a_rdata_valid, bus.a_rdata, ce_n, oe_n, addr} !== {2'b11, 16'hA0A0, 2'b00, 18'h00200}) begin n_fail++;
         $display("FAIL b2b_c3: got b_ack %b a_valid %b a_rdata %h ce/oe %b addr %h expected 1 1 A0A0 00 00200",
                  bus.b_ack, bus.a_rdata_valid, bus.a_rdata, {ce_n, oe_n}, addr); end
      bus.b_req = 1'b0;
      repeat (2) tick();
      n_checks++; if ({bus.b_rdata_valid, bus.b_rdata, bus.a_rdata_valid} !== {1'b1, 16'hB1B1, 1'b0}) begin n_fail++;
         $display("FAIL b2b_c5: got b_valid %b b_rdata %h a_valid %b expected 1 B1B1 0",
                  bus.b_rdata_valid, bus.b_rdata, bus.a_rdata_valid); end
      tick();
   endtask

   task automatic test_random;
      exp_t qa[$], qb[$];
      exp_t e;
      logic a_wait = 1'b0;
      int   bad_ack = 0;
      idle_inputs();
      for (int c = 0; c < 1500; c++) begin
         tick();
         if (bus.a_rdata_valid) begin
            n_checks++;
            if (qa.size() == 0 || qa[0].due != c || bus.a_rdata !== qa[0].data) begin n_fail++;
               $display("FAIL rand_a_data: cycle %0d got %h expected %h due %0d", c, bus.a_rdata,
                        qa.size() ? qa[0].data : 16'h0, qa.size() ? qa[0].due : -1); end
            if (qa.size() != 0) void'(qa.pop_front());
         end else if (qa.size() != 0 && qa[0].due <= c) begin
            n_checks++; n_fail++;
            $display("FAIL rand_a_missing: cycle %0d got no valid expected %h", c, qa[0].data);
            void'(qa.pop_front());
         end
         if (bus.b_rdata_valid) begin
            n_checks++;
            if (qb.size() == 0 || qb[0].due != c || bus.b_rdata !== qb[0].data) begin n_fail++;
               $display("FAIL rand_b_data: cycle %0d got %h expected %h due %0d", c, bus.b_rdata,
                        qb.size() ? qb[0].data : 16'h0, qb.size() ? qb[0].due : -1); end
            if (qb.size() != 0) void'(qb.pop_front());
         end else if (qb.size() != 0 && qb[0].due <= c) begin
            n_checks++; n_fail++;
            $display("FAIL rand_b_missing: cycle %0d got no valid expected %h", c, qb[0].data);
            void'(qb.pop_front());
         end
         if (bus.a_ack && bus.b_ack) bad_ack++;
         if (bus.b_ack && a_wait && !STARVE_EN) bad_ack++;
         if (bus.a_ack) begin
            e.due = c + 2; e.data = ref_rd(int'(bus.a_addr)); qa.push_back(e);
            bus.a_req = (c < 1490) && ($urandom_range(1) == 1);
            bus.a_addr = 18'($urandom_range(15));
         end
         if (bus.b_ack) begin
            if (bus.b_we) ref_wr(int'(bus.b_addr), bus.b_wdata, bus.b_be);
            else begin e.due = c + 2; e.data = ref_rd(int'(bus.b_addr)); qb.push_back(e); end
            bus.b_req = 1'b0;
         end
         if (!bus.a_req && c < 1490 && $urandom_range(3) == 0) begin
            bus.a_req = 1'b1; bus.a_addr = 18'($urandom_range(15));
         end
         if (!bus.b_req && c < 1490 && $urandom_range(2) == 0) begin
            bus.b_req = 1'b1; bus.b_we = 1'($urandom_range(1)); bus.b_addr = 18'($urandom_range(15));
            bus.b_be = 2'($urandom_range(3)); bus.b_wdata = 16'($urandom);
         end
         a_wait = bus.a_req;
      end
      n_checks++; if (bad_ack != 0) begin n_fail++;
         $display("FAIL rand_grant_rules: got %0d bad grants expected 0", bad_ack); end
      n_checks++; if (qa.size() + qb.size() != 0) begin n_fail++;
         $display("FAIL rand_drain: got %0d outstanding reads expected 0", qa.size() + qb.size()); end
      n_checks++; if (bus_viol != 0) begin n_fail++;
         $display("FAIL oe_with_dqe: got %0d cycles expected 0", bus_viol); end
   endtask

   initial begin
      for (int i = 0; i < 262144; i++) mem[i] = init_pat(i);
      idle_inputs();
      test_reset();
      test_a_read();
      test_b_write();
      test_starve();
      test_reset_mid_write();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
